recon_writeback: RTL and testbench

RECON_WRITEBACK -- requirements
Module: recon_writeback

---
 rtl/recon_pkg.sv | 26 ++
 rtl/recon_writeback_if.sv | 31 +++
 rtl/recon_writeback.sv | 130 +++++++++++++
 tb/tb_recon_writeback.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// Shared types and helpers for the reconstruction write-back block.
//   wb_state_t  : write-back FSM state (IDLE, LOAD, WRITE).
//   mb_row_addr : linear frame-memory pixel index of the leftmost pixel in
//                 row r of raster block mbnumber. All arithmetic is unsigned
//                 32-bit.
package recon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } wb_state_t;

    function automatic logic [31:0] mb_row_addr(
        input logic [31:0] mbnumber,
        input logic [31:0] r,
        input logic [31:0] width,
        input logic [31:0] mb_size_w,
        input logic [31:0] mb_size_l
    );
        logic [31:0] mbx;
        mbx = width / mb_size_w;
        return ((mbnumber / mbx) * mb_size_l + r) * width + (mbnumber % mbx) * mb_size_w;
    endfunction

endpackage

// File: rtl/recon_writeback_if.sv
// Block-input and frame-memory row-write channels of recon_writeback.
//   in_valid/in_ready : block handshake; mbnumber is the raster block index
//                       and reconst holds the block pixels (row-major,
//                       pixel 0 in the low byte).
//   wr_en/wr_ready    : row write handshake; wr_addr is the linear pixel
//                       index of the row's leftmost pixel, wr_data holds the
//                       row pixels (leftmost pixel in the low byte).
// Modports: slave = recon_writeback side, master = block source / memory.
interface recon_writeback_if #(
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4
);
    logic                               in_valid;
    logic                               in_ready;
    logic [31:0]                        mbnumber;
    logic [8*MB_SIZE_L*MB_SIZE_W-1:0]   reconst;
    logic                               wr_en;
    logic                               wr_ready;
    logic [31:0]                        wr_addr;
    logic [8*MB_SIZE_W-1:0]             wr_data;

    modport slave (
        input  in_valid, mbnumber, reconst, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, mbnumber, reconst, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/recon_writeback.sv
// recon_writeback: takes one reconstructed MB_SIZE_L x MB_SIZE_W block at a
// time and writes it to frame memory one row per accepted write.
// Ports:
//   clk        : clock, rising edge.
//   reset      : asynchronous, active-low reset.
//   bus        : recon_writeback_if.slave (block input + row write channels).
//   blk_done   : one-cycle pulse when the last row of a block is accepted.
//   frame_done : coincident with blk_done for the last block of the frame.
//   range_err  : sticky out-of-range flag, only with RECON_WB_RANGECHK_EN.
// Optional feature macro: RECON_WB_RANGECHK_EN (blocks with mbnumber >= NMB
// are accepted and dropped, and range_err is set until reset).
module recon_writeback
    import recon_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    recon_writeback_if.slave        bus,
    output logic                    blk_done,
    output logic                    frame_done
`ifdef RECON_WB_RANGECHK_EN
    ,
    output logic                    range_err
`endif
);

    localparam int MBX      = WIDTH / MB_SIZE_W;
    localparam int NMB      = MBX * (LENGTH / MB_SIZE_L);
    localparam int NPIX     = MB_SIZE_L * MB_SIZE_W;
    localparam int ROW_BITS = 8 * MB_SIZE_W;
    localparam int ROW_W    = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MB_SIZE_L - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [31:0]      LAST_MB  = 32'(NMB - 1);
    localparam logic [31:0]      WIDTH_U  = 32'(WIDTH);

    wb_state_t              state_reg, state_next;
    logic [8*NPIX-1:0]      blk_reg;
    logic [31:0]            mb_reg;
    logic [ROW_W-1:0]       row_reg;
    logic [31:0]            wr_addr_reg;
    // Holds in_ready low during reset and for the first cycle after it.
    logic                   ready_en_reg;

    logic                   accept;
    logic                   in_range;
    logic                   row_take;
    logic                   last_take;
    logic [ROW_BITS-1:0]    rows [MB_SIZE_L];

    for (genvar gi = 0; gi < MB_SIZE_L; gi++) begin : g_rows
        assign rows[gi] = blk_reg[gi*ROW_BITS +: ROW_BITS];
    end

`ifdef RECON_WB_RANGECHK_EN
    localparam logic [31:0] NMB_U = 32'(NMB);
    logic range_err_reg;

    assign in_range  = (bus.mbnumber < NMB_U);
    assign range_err = range_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_err_reg <= 1'b0;
        end else if (accept && !in_range) begin
            range_err_reg <= 1'b1;
        end
    end
`else
    assign in_range = 1'b1;
`endif

    assign row_take  = (state_reg == WRITE) && bus.wr_ready;
    assign last_take = row_take && (row_reg == LAST_ROW);

    // Ready in IDLE, and also on the cycle the last row leaves so the next
    // block can be taken without an idle bubble.
    assign bus.in_ready = ready_en_reg && ((state_reg == IDLE) || last_take);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.wr_en    = (state_reg == WRITE);
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = (state_reg == WRITE) ? rows[row_reg] : '0;

    assign blk_done     = last_take;
    assign frame_done   = last_take && (mb_reg == LAST_MB);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && in_range) state_next = LOAD;
            LOAD:    state_next = WRITE;
            WRITE:   if (last_take) state_next = (accept && in_range) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            blk_reg      <= '0;
            mb_reg       <= '0;
            row_reg      <= '0;
            wr_addr_reg  <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            state_reg    <= state_next;
            // The block input is only sampled on the accept edge.
            if (accept && in_range) begin
                blk_reg <= bus.reconst;
                mb_reg  <= bus.mbnumber;
            end
            if (state_reg == LOAD) begin
                wr_addr_reg <= mb_row_addr(mb_reg, 32'd0, WIDTH_U,
                                           32'(MB_SIZE_W), 32'(MB_SIZE_L));
                row_reg     <= '0;
            end else if (row_take) begin
                // Next row of the same block is exactly one frame line down.
                wr_addr_reg <= wr_addr_reg + WIDTH_U;
                row_reg     <= (row_reg == LAST_ROW) ? '0 : row_reg + ROW_ONE;
            end
        end
    end

endmodule

// File: tb/tb_recon_writeback.sv
// Directed bench for recon_writeback with a 16x8 frame and 4x4 blocks
// (MBX = 4, NMB = 8). Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_recon_writeback;

    logic clk;
    logic reset;
    logic blk_done;
    logic frame_done;
`ifdef RECON_WB_RANGECHK_EN
    logic range_err;
`endif

    int checks = 0;
    int errors = 0;

    recon_writeback_if #(.MB_SIZE_L(4), .MB_SIZE_W(4)) bus ();

    recon_writeback #(
        .WIDTH(16), .LENGTH(8), .MB_SIZE_L(4), .MB_SIZE_W(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .blk_done   (blk_done),
        .frame_done (frame_done)
`ifdef RECON_WB_RANGECHK_EN
        ,
        .range_err  (range_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (reset && bus.in_valid && bus.in_ready)
            $display("accept block mb=%0d", bus.mbnumber);
        if (reset && bus.wr_en && bus.wr_ready)
            $display("row write addr=%0d data=%h blk_done=%0b frame_done=%0b",
                     bus.wr_addr, bus.wr_data, blk_done, frame_done);
    end

    function automatic logic [127:0] make_block(input int base);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = 8'(base + k);
        return b;
    endfunction

    function automatic logic [31:0] row_of(input int base, input int r);
        logic [31:0] d;
        for (int p = 0; p < 4; p++) d[8*p +: 8] = 8'(base + 4*r + p);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.mbnumber = '0;
        bus.reconst = '0;
        bus.wr_ready = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL reset_blk_done: got %b expected 0", blk_done); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (bus.wr_addr !== 32'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", bus.wr_data); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready_early: got %b expected 0", bus.in_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
    endtask

    // mb=5 pixels 0..15, row addresses 68/84/100/116, blk_done 5 cycles on.
    task automatic test_single();
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd5; bus.reconst = make_block(0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_load_wr_en: got %b expected 0", bus.wr_en); end
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en r%0d: got %b expected 1", r, bus.wr_en); end
            checks++; if (bus.wr_addr !== 32'(68 + 16*r)) begin errors++; $display("FAIL single_addr r%0d: got %0d expected %0d", r, bus.wr_addr, 68 + 16*r); end
            checks++; if (bus.wr_data !== row_of(0, r)) begin errors++; $display("FAIL single_data r%0d: got %h expected %h", r, bus.wr_data, row_of(0, r)); end
            checks++; if (blk_done !== (r == 3)) begin errors++; $display("FAIL single_blk_done r%0d: got %b expected %b", r, blk_done, r == 3); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_frame_done r%0d: got %b expected 0", r, frame_done); end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_idle_wr_en: got %b expected 0", bus.wr_en); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected 1", bus.in_ready); end
    endtask

    // mb=7 is the last block of the frame: rows 76..124, frame_done on last row.
    task automatic test_frame_end();
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd7; bus.reconst = make_block(100);
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.wr_addr !== 32'(76 + 16*r)) begin errors++; $display("FAIL frame_addr r%0d: got %0d expected %0d", r, bus.wr_addr, 76 + 16*r); end
            checks++; if (bus.wr_data !== row_of(100, r)) begin errors++; $display("FAIL frame_data r%0d: got %h expected %h", r, bus.wr_data, row_of(100, r)); end
            checks++; if (blk_done !== (r == 3)) begin errors++; $display("FAIL frame_blk_done r%0d: got %b expected %b", r, blk_done, r == 3); end
            checks++; if (frame_done !== (r == 3)) begin errors++; $display("FAIL frame_frame_done r%0d: got %b expected %b", r, frame_done, r == 3); end
        end
        tick();
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse: got %b expected 0", frame_done); end
    endtask

    // wr_ready low for 3 cycles on row 1: blk_done moves from cycle 5 to 8.
    task automatic test_stall();
        int r_exp;
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd5; bus.reconst = make_block(32);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            bus.wr_ready = !(k >= 3 && k <= 5);
            @(negedge clk);
            r_exp = (k == 2) ? 0 : (k <= 6) ? 1 : k - 5;
            checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL stall_wr_en c%0d: got %b expected 1", k, bus.wr_en); end
            checks++; if (bus.wr_addr !== 32'(68 + 16*r_exp)) begin errors++; $display("FAIL stall_addr c%0d: got %0d expected %0d", k, bus.wr_addr, 68 + 16*r_exp); end
            checks++; if (bus.wr_data !== row_of(32, r_exp)) begin errors++; $display("FAIL stall_data c%0d: got %h expected %h", k, bus.wr_data, row_of(32, r_exp)); end
            checks++; if (blk_done !== (k == 8)) begin errors++; $display("FAIL stall_blk_done c%0d: got %b expected %b", k, blk_done, k == 8); end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL stall_idle_wr_en: got %b expected 0", bus.wr_en); end
    endtask

    // in_valid held high: block 1 accepted on block 0's last-row cycle.
    task automatic test_back_to_back();
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd0; bus.reconst = make_block(64);
        tick();
        bus.mbnumber = 32'd1; bus.reconst = make_block(128);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_load_ready: got %b expected 0", bus.in_ready); end
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.wr_addr !== 32'(16*r)) begin errors++; $display("FAIL b2b_addr0 r%0d: got %0d expected %0d", r, bus.wr_addr, 16*r); end
            checks++; if (bus.wr_data !== row_of(64, r)) begin errors++; $display("FAIL b2b_data0 r%0d: got %h expected %h", r, bus.wr_data, row_of(64, r)); end
            checks++; if (bus.in_ready !== (r == 3)) begin errors++; $display("FAIL b2b_ready r%0d: got %b expected %b", r, bus.in_ready, r == 3); end
            checks++; if (blk_done !== (r == 3)) begin errors++; $display("FAIL b2b_blk_done0 r%0d: got %b expected %b", r, blk_done, r == 3); end
        end
        tick();
        bus.in_valid = 1'b0; bus.reconst = make_block(200);
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL b2b_gap_wr_en: got %b expected 0", bus.wr_en); end
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.wr_addr !== 32'(4 + 16*r)) begin errors++; $display("FAIL b2b_addr1 r%0d: got %0d expected %0d", r, bus.wr_addr, 4 + 16*r); end
            checks++; if (bus.wr_data !== row_of(128, r)) begin errors++; $display("FAIL b2b_data1 r%0d: got %h expected %h", r, bus.wr_data, row_of(128, r)); end
            checks++; if (blk_done !== (r == 3)) begin errors++; $display("FAIL b2b_blk_done1 r%0d: got %b expected %b", r, blk_done, r == 3); end
        end
        tick();
    endtask

    // Reset during row 2 of mb=2, then mb=3 writes from row 0.
    task automatic test_reset_mid();
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd2; bus.reconst = make_block(16);
        tick();
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.wr_addr !== 32'd8) begin errors++; $display("FAIL rmid_row0_addr: got %0d expected 8", bus.wr_addr); end
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b expected 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 32'd0) begin errors++; $display("FAIL rmid_wr_addr: got %0d expected 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rmid_wr_data: got %h expected 0", bus.wr_data); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL rmid_blk_done: got %b expected 0", blk_done); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rmid_release_wr_en: got %b expected 0", bus.wr_en); end
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd3; bus.reconst = make_block(48);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_again: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.wr_addr !== 32'(12 + 16*r)) begin errors++; $display("FAIL rmid_addr r%0d: got %0d expected %0d", r, bus.wr_addr, 12 + 16*r); end
            checks++; if (bus.wr_data !== row_of(48, r)) begin errors++; $display("FAIL rmid_data r%0d: got %h expected %h", r, bus.wr_data, row_of(48, r)); end
            checks++; if (blk_done !== (r == 3)) begin errors++; $display("FAIL rmid_blk_done r%0d: got %b expected %b", r, blk_done, r == 3); end
        end
        tick();
    endtask

`ifdef RECON_WB_RANGECHK_EN
    // mb=8 is outside the frame: accepted, dropped, range_err sticky.
    task automatic test_range();
        tick();
        bus.in_valid = 1'b1; bus.mbnumber = 32'd8; bus.reconst = make_block(0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL range_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_err_before: got %b expected 0", range_err); end
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL range_wr_en c%0d: got %b expected 0", k, bus.wr_en); end
            checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL range_blk_done c%0d: got %b expected 0", k, blk_done); end
            checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err_sticky c%0d: got %b expected 1", k, range_err); end
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_err_reset: got %b expected 0", range_err); end
        tick();
        reset = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_frame_end();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef RECON_WB_RANGECHK_EN
        test_range();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
